mult_datapath: RTL and testbench

MULT_DATAPATH -- requirements
Module: mult_datapath

---
 rtl/mult_datapath_pkg.sv | 9 +
 rtl/mult_datapath_if.sv | 26 ++
 rtl/mult_datapath_rom.sv | 11 +
 rtl/mult_datapath.sv | 60 ++++++
 tb/tb_mult_datapath.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mult_datapath_pkg.sv
// mult_datapath_pkg: shared defaults, operand ROM contents and controller state codes
package mult_datapath_pkg;
  localparam int OPW_DEF = 4;
  localparam int DEPTH_DEF = 8;
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} state_e;
  function automatic int unsigned rom_val(input logic [2:0] a);
    return {28'd0, a, 1'b1};
  endfunction
endpackage

// File: rtl/mult_datapath_if.sv
// mult_datapath_if: controller-side strobes and datapath status outputs
interface mult_datapath_if
  import mult_datapath_pkg::*;
#(
  parameter int OPW = OPW_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int AW = $clog2(DEPTH);
  logic w_rf;
  logic [2:0] adr;
  logic DA;
  logic SA;
  logic SB;
  logic w_ram;
  logic [AW-1:0] rd_adr;
  logic [2*OPW-1:0] product;
  logic [2*OPW-1:0] ram_dout;
  logic [AW-1:0] wr_ptr;
  logic [AW:0] count;
  logic full;
  logic wr_done;
  modport master (output w_rf, adr, DA, SA, SB, w_ram, rd_adr,
                  input product, ram_dout, wr_ptr, count, full, wr_done);
  modport slave (input w_rf, adr, DA, SA, SB, w_ram, rd_adr,
                 output product, ram_dout, wr_ptr, count, full, wr_done);
endinterface

// File: rtl/mult_datapath_rom.sv
// operand_rom: combinational operand table, entry i holds 2*i+1
module operand_rom
  import mult_datapath_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic [2:0]     adr_i,
  output logic [OPW-1:0] data_o
);
  assign data_o = OPW'(rom_val(adr_i));
endmodule

// File: rtl/mult_datapath.sv
// mult_datapath: two-entry register file, multiplier and circular result RAM
module mult_datapath
  import mult_datapath_pkg::*;
#(
  parameter int OPW = OPW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic reset,
  mult_datapath_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [OPW-1:0] rom_data, op_a, op_b;
  logic [OPW-1:0] r_q [2];
  logic [2*OPW-1:0] mul, product_q, ram_dout_q;
  logic [2*OPW-1:0] ram_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] count_q, count_d;
  logic w_ram_q, wr_done_q, we;
  operand_rom #(.OPW(OPW)) u_rom (.adr_i(bus.adr), .data_o(rom_data));
  assign op_a = bus.SA ? r_q[1] : r_q[0];
  assign op_b = bus.SB ? r_q[1] : r_q[0];
  assign mul = {{OPW{1'b0}}, op_a} * {{OPW{1'b0}}, op_b};
  assign we = bus.w_ram & ~w_ram_q;
  // write pointer wraps freely; count saturates so a full RAM keeps overwriting the oldest slot
  always_comb begin
    wr_ptr_d = we ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d = (we && count_q != FULL_CNT) ? count_q + (AW+1)'(1) : count_q;
  end
  // all state; RAM write uses pre-edge register values so a same-edge w_rf load does not leak in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q[0] <= '0;
      r_q[1] <= '0;
      product_q <= '0;
      ram_dout_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      w_ram_q <= 1'b0;
      wr_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else begin
      if (bus.w_rf) r_q[bus.DA] <= rom_data;
      product_q <= mul;
      ram_dout_q <= ram_q[bus.rd_adr];
      w_ram_q <= bus.w_ram;
      wr_done_q <= we;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      if (we) ram_q[wr_ptr_q] <= mul;
    end
  end
  assign bus.product = product_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.wr_ptr = wr_ptr_q;
  assign bus.count = count_q;
  assign bus.full = count_q == FULL_CNT;
  assign bus.wr_done = wr_done_q;
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed sequence with a write scoreboard checked on read-back
module tb_mult_datapath;
  import mult_datapath_pkg::*;
  typedef struct {int a; int d;} ent_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  int mr [2];
  int mram [8];
  int mptr = 0;
  int mcnt = 0;
  ent_t sb [$];
  mult_datapath_if bus ();
  mult_datapath dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input int a, input bit da);
    bus.w_rf = 1'b1;
    bus.adr = 3'(a);
    bus.DA = da;
    tick();
    mr[da] = 2 * a + 1;
    bus.w_rf = 1'b0;
  endtask
  task automatic wr(input bit ld, input int a, input bit da);
    int exp, old;
    ent_t e;
    exp = mr[bus.SA] * mr[bus.SB];
    old = mram[mptr];
    bus.w_ram = 1'b1;
    bus.w_rf = ld;
    bus.adr = 3'(a);
    bus.DA = da;
    bus.rd_adr = 3'(mptr);
    sb.push_back('{mptr, exp});
    tick();
    if (ld) mr[da] = 2 * a + 1;
    mram[mptr] = exp;
    mptr = (mptr + 1) % 8;
    if (mcnt < 8) mcnt++;
    chk("rd_old", 32'(bus.ram_dout), old);
    chk("product", 32'(bus.product), exp);
    chk("wr_done_hi", 32'(bus.wr_done), 1);
    chk("wr_ptr", 32'(bus.wr_ptr), mptr);
    chk("count", 32'(bus.count), mcnt);
    chk("full", 32'(bus.full), 32'(mcnt == 8));
    bus.w_ram = 1'b0;
    bus.w_rf = 1'b0;
    e = sb.pop_front();
    bus.rd_adr = 3'(e.a);
    tick();
    chk("wr_done_lo", 32'(bus.wr_done), 0);
    chk("ram_rd", 32'(bus.ram_dout), e.d);
  endtask
  initial begin
    bus.w_rf = 0; bus.adr = 0; bus.DA = 0; bus.SA = 0; bus.SB = 1;
    bus.w_ram = 0; bus.rd_adr = 0;
    mr[0] = 0; mr[1] = 0;
    for (int i = 0; i < 8; i++) mram[i] = 0;
    #3;
    chk("rst_product", 32'(bus.product), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_wr_done", 32'(bus.wr_done), 0);
    tick();
    reset = 1'b1;
    load(2, 0);
    load(3, 1);
    tick();
    chk("product_5x7", 32'(bus.product), 32'h23);
    wr(0, 0, 0);
    chk("ram0_first", 32'(mram[0]), 32'h23);
    bus.w_ram = 1'b1;
    bus.rd_adr = 0;
    tick();
    mram[1] = mr[0] * mr[1]; mptr = 2; mcnt = 2;
    chk("hold_count", 32'(bus.count), 2);
    chk("hold_wr_done", 32'(bus.wr_done), 1);
    tick();
    chk("hold_wr_done_lo", 32'(bus.wr_done), 0);
    tick();
    chk("hold_count_stay", 32'(bus.count), 2);
    chk("hold_wr_ptr", 32'(bus.wr_ptr), 2);
    bus.w_ram = 1'b0;
    tick();
    load(0, 1);
    for (int k = 1; k <= 7; k++) wr(1, k, 1);
    chk("full_count", 32'(bus.count), 8);
    chk("full_flag", 32'(bus.full), 1);
    chk("full_wr_ptr", 32'(bus.wr_ptr), 1);
    bus.rd_adr = 0;
    tick();
    chk("ram0_ninth", 32'(bus.ram_dout), 65);
    load(7, 0);
    load(7, 1);
    tick();
    chk("product_15x15", 32'(bus.product), 32'hE1);
    for (int k = 0; k < 3; k++) wr(0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_product", 32'(bus.product), 0);
    chk("arst_ram_dout", 32'(bus.ram_dout), 0);
    chk("arst_wr_ptr", 32'(bus.wr_ptr), 0);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_full", 32'(bus.full), 0);
    chk("arst_wr_done", 32'(bus.wr_done), 0);
    bus.w_ram = 1'b1;
    bus.rd_adr = 0;
    #3;
    reset = 1'b1;
    tick();
    chk("rel_count", 32'(bus.count), 1);
    chk("rel_wr_done", 32'(bus.wr_done), 1);
    chk("rel_wr_ptr", 32'(bus.wr_ptr), 1);
    tick();
    chk("rel_count_once", 32'(bus.count), 1);
    chk("rel_wr_done_lo", 32'(bus.wr_done), 0);
    bus.w_ram = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rd_adr = 3'(i);
      tick();
      chk("post_rst_ram", 32'(bus.ram_dout), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
